// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing the 32-bit mux41 between four requesters.
// Optional forced release after MAX_HOLD cycles: define ARB_TIMEOUT_EN.
module mux41_rr_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] REQ,
   output logic [3:0] GNT,
   output logic [1:0] SEL,
   output logic       BUSY,
   output logic       TIMEOUT
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   if (MAX_HOLD < 2) begin : g_bad_hold
      $error("MAX_HOLD must be at least 2");
   end

   state_t     state;
   logic [1:0] last;
   logic [1:0] win;
   logic [1:0] idx;
   logic       found;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0] cnt;
`endif

   // Rotating priority scan starting just after the last owner
   always_comb begin
      win   = last;
      idx   = last;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!found && REQ[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Grant FSM with hold counter and forced release
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         GNT     <= 4'b0000;
         SEL     <= 2'b00;
         BUSY    <= 1'b0;
         TIMEOUT <= 1'b0;
         last    <= 2'd3;
         cnt     <= '0;
      end else begin
         TIMEOUT <= 1'b0;
         case (state)
            IDLE: begin
               GNT <= 4'b0000;
               if (|REQ) begin
                  state <= GRANT;
                  GNT   <= 4'b0001 << win;
                  SEL   <= win;
                  BUSY  <= 1'b1;
                  last  <= win;
                  cnt   <= CW'(1);
               end
            end
            GRANT: begin
               if (!REQ[last]) begin
                  state <= IDLE;
                  GNT   <= 4'b0000;
                  BUSY  <= 1'b0;
               end else if (cnt == CW'(MAX_HOLD)) begin
                  state   <= IDLE;
                  GNT     <= 4'b0000;
                  BUSY    <= 1'b0;
                  TIMEOUT <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               GNT   <= 4'b0000;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end
`else
   assign TIMEOUT = 1'b0;

   // Grant FSM; an owner keeps the mux until it drops its request
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         GNT   <= 4'b0000;
         SEL   <= 2'b00;
         BUSY  <= 1'b0;
         last  <= 2'd3;
      end else begin
         case (state)
            IDLE: begin
               GNT <= 4'b0000;
               if (|REQ) begin
                  state <= GRANT;
                  GNT   <= 4'b0001 << win;
                  SEL   <= win;
                  BUSY  <= 1'b1;
                  last  <= win;
               end
            end
            GRANT: begin
               if (!REQ[last]) begin
                  state <= IDLE;
                  GNT   <= 4'b0000;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               GNT   <= 4'b0000;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed-vector bench for mux41_rr_arbiter (MAX_HOLD = 4).
// Expected grants are hand-computed per step; a tiny mux41 model checks OUT.
module tb_mux41_rr_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  REQ = 4'b0000;
   logic [3:0]  GNT;
   logic [1:0]  SEL;
   logic        BUSY;
   logic        TIMEOUT;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] ins [4];
   logic [31:0] mux_out;

   mux41_rr_arbiter #(.MAX_HOLD(4)) dut (
      .CLK(CLK),
      .RST(RST),
      .REQ(REQ),
      .GNT(GNT),
      .SEL(SEL),
      .BUSY(BUSY),
      .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   assign mux_out = ins[SEL];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_st(input string tag, input logic [3:0] g,
                            input logic [1:0] s, input logic b,
                            input logic t);
      chk({tag, ".gnt"}, 32'(GNT), 32'(g));
      chk({tag, ".sel"}, 32'(SEL), 32'(s));
      chk({tag, ".busy"}, 32'(BUSY), 32'(b));
      chk({tag, ".tmo"}, 32'(TIMEOUT), 32'(t));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      REQ = 4'b0000;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      logic [3:0] oh;
      ins[0] = 32'hAAAA0000;
      ins[1] = 32'hBBBB1111;
      ins[2] = 32'h12345678;
      ins[3] = 32'hDDDD3333;

      // reset and idle
      step();
      expect_st("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_st("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      end

      // single requester 2 for four cycles
      REQ = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_st("r2", 4'b0100, 2'd2, 1'b1, 1'b0);
         chk("r2.out", mux_out, 32'h12345678);
      end
      REQ = 4'b0000;
      step();
      expect_st("r2rel", 4'b0000, 2'd2, 1'b0, 1'b0);

      // rotation 0,1,2,3,0 under full load
      do_reset();
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         REQ = 4'b1111;
         step();
         expect_st("rr.g", oh, 2'(k % 4), 1'b1, 1'b0);
         step();
         expect_st("rr.h", oh, 2'(k % 4), 1'b1, 1'b0);
         REQ = 4'b1111 & ~oh;
         step();
         expect_st("rr.bub", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
      end

      // no preemption: 3 waits for 1 to release
      REQ = 4'b0010;
      step();
      expect_st("np.g1", 4'b0010, 2'd1, 1'b1, 1'b0);
      REQ = 4'b1010;
      step();
      expect_st("np.h1", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
      expect_st("np.h2", 4'b0010, 2'd1, 1'b1, 1'b0);
      REQ = 4'b1000;
      step();
      expect_st("np.bub", 4'b0000, 2'd1, 1'b0, 1'b0);
      step();
      expect_st("np.g3", 4'b1000, 2'd3, 1'b1, 1'b0);
      REQ = 4'b0000;
      step();
      expect_st("np.rel", 4'b0000, 2'd3, 1'b0, 1'b0);

      // async reset mid-grant
      REQ = 4'b0100;
      step();
      expect_st("ar.g", 4'b0100, 2'd2, 1'b1, 1'b0);
      #2;
      RST = 1'b1;
      #1;
      chk("ar.gnt", 32'(GNT), 32'h0);
      chk("ar.busy", 32'(BUSY), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      REQ = 4'b1111;
      step();
      expect_st("ar.first", 4'b0001, 2'd0, 1'b1, 1'b0);
      REQ = 4'b0000;
      step();

      // long holder 0 with 2 waiting
      do_reset();
      REQ = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_st("to.hold", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
`ifdef ARB_TIMEOUT_EN
      step();
      expect_st("to.pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
      step();
      expect_st("to.next", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
      for (int i = 0; i < 4; i++) begin
         step();
         expect_st("to.keep", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
`endif
      REQ = 4'b0000;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter/controller that shares the 32-bit 4:1 mux (mux41) between four requesters.
- Grants one requester at a time, holds the grant while that requester keeps its request asserted, and drives the mux SEL with the winner's index.
- Sits beside mux41 in the Proyecto_2 datapath: this block's SEL output connects directly to mux41.SEL, and its GNT output tells each source when its IN word is on OUT.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; used only when the optional feature is compiled in. Legal range ≥ 2.

Ports:
- CLK  input  1  system clock, rising-edge
- RST  input  1  asynchronous, active-high reset
- REQ  input  4  REQ[i] = requester i wants the mux; held high for the whole transfer
- GNT  output 4  one-hot grant; GNT[i] = IN(i) is routed to OUT; all-zero when idle
- SEL  output 2  mux select, drives mux41.SEL
- BUSY output 1  1 while in GRANT state
- TIMEOUT output 1  one-cycle pulse on forced release; constant 0 without the optional feature

Behaviour:
- One clock domain (CLK). RST is asynchronous and active-high. All outputs are registered.
- Reset values:
  - GNT = 4'b0000, SEL = 2'b00, BUSY = 0, TIMEOUT = 0.
  - State = IDLE.
  - Last-owner pointer LAST = 2'd3, so requester 0 has first priority.
  - Hold counter = 0.
- State IDLE:
  - If REQ != 0, pick the first set REQ bit scanning LAST+1, LAST+2, LAST+3, LAST+4 (mod 4).
  - At the next edge: state = GRANT, GNT = onehot(winner), SEL = winner, BUSY = 1, LAST = winner, counter = 1.
  - If REQ == 0, remain in IDLE. GNT = 0; SEL holds its last value.
- Latency: REQ rising in IDLE in cycle n gives GNT/SEL valid after edge n+1, i.e. one cycle of latency.
- State GRANT:
  - While REQ[LAST] = 1, hold GNT/SEL unchanged and increment the counter.
  - When REQ[LAST] = 0 is sampled, at the next edge: state = IDLE, GNT = 0, BUSY = 0.
- Mandatory idle bubble: at least one IDLE cycle separates consecutive grants, including re-grant to the same requester. This gives back-to-back throughput of one owner change per two cycles minimum.
- Other requests during GRANT: changes on other REQ bits are ignored. No preemption.
- Fairness: the new LAST excludes the previous owner from top priority next round. Any continuously requesting source is granted within 4 arbitration rounds.
- Simultaneous release and new requests: release is processed first (IDLE bubble). Arbitration occurs in the IDLE cycle using REQ sampled there.
- REQ = 4'b1111 continuously, each owner dropping after k cycles: grant order 0,1,2,3,0,…
- Reset mid-grant: GNT clears immediately (asynchronously), LAST returns to 3, state = IDLE.
- Invariants: GNT is always one-hot or zero; SEL == index of the set GNT bit whenever BUSY = 1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter width is $clog2(MAX_HOLD+1).
  - If in GRANT the counter equals MAX_HOLD and REQ[LAST] is still 1, the next edge forces state = IDLE, GNT = 0, BUSY = 0, TIMEOUT = 1 for exactly one cycle.
  - The forced owner loses priority normally (LAST already points to it).
  - If the owner keeps REQ high, it is re-granted only after other requesters are served.
- Undefined: no counter logic; grant holds indefinitely; TIMEOUT tied to 0.

Test Plan:
- RST=1 then release, REQ=0 for 5 cycles → GNT=0000, SEL=00, BUSY=0, TIMEOUT=0 throughout.
- REQ=0100 at cycle 3, held 4 cycles → GNT=0100, SEL=10 from cycle 4 for 4 cycles; mux41 OUT equals IN2 (32'h12345678); then GNT=0000.
- REQ=1111 constantly, each owner drops its REQ bit 2 cycles after grant, then reasserts → grant order 0,1,2,3,0 with one idle cycle between grants; SEL sequence 00,01,10,11,00.
- Owner 1 granted, REQ[3] asserted mid-grant → GNT stays 0010 until REQ[1] drops, then one idle cycle, then GNT=1000, SEL=11.
- Assert RST asynchronously while GNT=0100 → GNT=0000, BUSY=0 before the next edge; after release, REQ=1111 grants requester 0 first.
- With ARB_TIMEOUT_EN, MAX_HOLD=4, REQ=0001 held forever plus REQ[2] set → GNT=0001 for 4 cycles, TIMEOUT pulses once, then GNT=0100; without the macro, GNT=0001 indefinitely and TIMEOUT stays 0.
